// File: rtl/rtl_settings_pkg.sv
// Shared types and defaults for the memory test sequencer: FSM state encoding and the
// two-word test descriptor in the controller's [2:1][31:0] layout (word 2 in the upper half).
package rtl_settings_pkg;

    localparam int DEF_PROG_DEPTH = 8;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        NEXT,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic [31:0] w2;
        logic [31:0] w1;
    } test_desc_t;

endpackage

// File: rtl/mem_seq_prog_ram.sv
// Descriptor store: PROG_DEPTH x 64 bits, 32-bit half-word writes, one synchronous read port.
// Read data appears one cycle after the address; no backpressure, storage is never reset.
module mem_seq_prog_ram
    import rtl_settings_pkg::*;
#(
    parameter int PROG_DEPTH = DEF_PROG_DEPTH,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          word_sel,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output test_desc_t    rdata
);

    test_desc_t mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (word_sel) mem[waddr].w2 <= wdata;
            else          mem[waddr].w1 <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Replays stored test descriptors into the test controller for N passes and tallies pass/fail;
// first start_test_o two cycles after run_i, then one test in flight at a time. Optional watchdog: MEM_SEQ_TIMEOUT_EN.
module mem_test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter int PROG_DEPTH = DEF_PROG_DEPTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOOP_W     = 8,
    parameter int TIMEOUT_W  = 24,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_we_i,
    input  logic [AW-1:0]     prog_addr_i,
    input  logic              prog_word_i,
    input  logic [31:0]       prog_data_i,
    input  logic [AW:0]       prog_len_i,
    input  logic [LOOP_W-1:0] loops_i,
    input  logic              stop_on_err_i,
    input  logic              run_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic              first_fail_valid_o,
    output logic [AW-1:0]     first_fail_idx_o,
    output logic              start_test_o,
    output logic [2:1][31:0]  test_param_o,
    input  logic              test_finish_i,
    input  logic              test_result_i,
    output logic              timeout_o
);

    seq_state_t        state;
    logic [AW-1:0]     idx, idx_inc, rd_addr;
    logic [AW:0]       len_q;
    logic [LOOP_W-1:0] loops_q, pass_q;
    logic              soe_q, abort_pend, last_fail, start_q;
    logic              last_slot, loop_done;
    test_desc_t        rd_dat, param_q;

    assign last_slot = ({1'b0, idx} == len_q - 1'b1);
    assign idx_inc   = last_slot ? '0 : idx + 1'b1;
    assign loop_done = last_slot && (loops_q != '0) && (pass_q + 1'b1 == loops_q);

    // Address the RAM one cycle ahead so the slot's data is ready when LOAD captures it.
    always_comb begin
        rd_addr = idx;
        if (state == IDLE)      rd_addr = '0;
        else if (state == NEXT) rd_addr = idx_inc;
    end

    mem_seq_prog_ram #(.PROG_DEPTH(PROG_DEPTH)) u_prog_ram (
        .clk      (clk_i),
        .we       (prog_we_i && (state == IDLE)),
        .waddr    (prog_addr_i),
        .word_sel (prog_word_i),
        .wdata    (prog_data_i),
        .raddr    (rd_addr),
        .rdata    (rd_dat)
    );

    assign busy_o       = (state != IDLE);
    assign test_param_o = param_q;
    // An abort landing in START must still suppress the start pulse.
    assign start_test_o = start_q & ~abort_i;

`ifdef MEM_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd;
    logic                 timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = (TIMEOUT_W < 1);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= IDLE;
            idx                <= '0;
            len_q              <= '0;
            loops_q            <= '0;
            pass_q             <= '0;
            soe_q              <= 1'b0;
            abort_pend         <= 1'b0;
            last_fail          <= 1'b0;
            start_q            <= 1'b0;
            done_o             <= 1'b0;
            pass_cnt_o         <= '0;
            fail_cnt_o         <= '0;
            first_fail_valid_o <= 1'b0;
            first_fail_idx_o   <= '0;
            param_q            <= '0;
`ifdef MEM_SEQ_TIMEOUT_EN
            wd                 <= '0;
            timeout_q          <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: if (run_i && !abort_i) begin
                    pass_cnt_o         <= '0;
                    fail_cnt_o         <= '0;
                    first_fail_valid_o <= 1'b0;
                    first_fail_idx_o   <= '0;
                    idx                <= '0;
                    pass_q             <= '0;
                    len_q              <= prog_len_i;
                    loops_q            <= loops_i;
                    soe_q              <= stop_on_err_i;
                    abort_pend         <= 1'b0;
                    last_fail          <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
                    timeout_q          <= 1'b0;
`endif
                    if (prog_len_i == '0 || prog_len_i > (AW+1)'(PROG_DEPTH)) state <= FINISH;
                    else                                                      state <= LOAD;
                end
                LOAD: begin
                    if (abort_i) state <= FINISH;
                    else begin
                        param_q <= rd_dat;
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
`ifdef MEM_SEQ_TIMEOUT_EN
                    wd <= '0;
`endif
                    state <= abort_i ? FINISH : WAIT;
                end
                WAIT: begin
                    if (abort_i) abort_pend <= 1'b1;
                    if (test_finish_i) begin
                        if (test_result_i) begin
                            if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
                            if (!first_fail_valid_o) begin
                                first_fail_valid_o <= 1'b1;
                                first_fail_idx_o   <= idx;
                            end
                        end else if (pass_cnt_o != '1) begin
                            pass_cnt_o <= pass_cnt_o + 1'b1;
                        end
                        last_fail <= test_result_i;
                        state     <= NEXT;
                    end
`ifdef MEM_SEQ_TIMEOUT_EN
                    else if (wd == '1) begin
                        if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
                        if (!first_fail_valid_o) begin
                            first_fail_valid_o <= 1'b1;
                            first_fail_idx_o   <= idx;
                        end
                        timeout_q <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                NEXT: begin
                    if (abort_pend || abort_i || (soe_q && last_fail) || loop_done) begin
                        state <= FINISH;
                    end else begin
                        idx <= idx_inc;
                        if (last_slot && loops_q != '0) pass_q <= pass_q + 1'b1;
                        state <= LOAD;
                    end
                end
                FINISH: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Scoreboard bench for mem_test_sequencer: expected starts and run results are queued by the
// stimulus, a negedge monitor checks them as the DUT presents start_test_o / done_o.
module tb_mem_test_sequencer;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             prog_we_i;
    logic [2:0]       prog_addr_i;
    logic             prog_word_i;
    logic [31:0]      prog_data_i;
    logic [3:0]       prog_len_i;
    logic [7:0]       loops_i;
    logic             stop_on_err_i;
    logic             run_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic [15:0]      pass_cnt_o;
    logic [15:0]      fail_cnt_o;
    logic             first_fail_valid_o;
    logic [2:0]       first_fail_idx_o;
    logic             start_test_o;
    logic [2:1][31:0] test_param_o;
    logic             test_finish_i;
    logic             test_result_i;
    logic             timeout_o;

    always #5 clk_i = ~clk_i;

    mem_test_sequencer #(.TIMEOUT_W(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .prog_we_i          (prog_we_i),
        .prog_addr_i        (prog_addr_i),
        .prog_word_i        (prog_word_i),
        .prog_data_i        (prog_data_i),
        .prog_len_i         (prog_len_i),
        .loops_i            (loops_i),
        .stop_on_err_i      (stop_on_err_i),
        .run_i              (run_i),
        .abort_i            (abort_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pass_cnt_o         (pass_cnt_o),
        .fail_cnt_o         (fail_cnt_o),
        .first_fail_valid_o (first_fail_valid_o),
        .first_fail_idx_o   (first_fail_idx_o),
        .start_test_o       (start_test_o),
        .test_param_o       (test_param_o),
        .test_finish_i      (test_finish_i),
        .test_result_i      (test_result_i),
        .timeout_o          (timeout_o)
    );

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] f;
        logic        v;
        logic [2:0]  i;
    } dexp_t;

    logic [63:0] start_q[$];
    dexp_t       done_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_starts = 0;
    int          n_done  = 0;
    int          fail_slot = -1;
    bit          hold = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_start(input int slot);
        start_q.push_back({32'h2000_0000 + slot, 32'h1000_0000 + slot});
    endtask

    task automatic push_done(input int p, input int f, input bit v, input int i);
        dexp_t d;
        d.p = 16'(p); d.f = 16'(f); d.v = v; d.i = 3'(i);
        done_q.push_back(d);
    endtask

    // Monitor: every start and every done is checked against the queued expectation.
    always begin
        logic [63:0] e;
        dexp_t       d;
        @(negedge clk_i);
        if (start_test_o) begin
            n_starts++;
            if (start_q.size() == 0) chk("unexpected_start", 64'(n_starts), 64'(0));
            else begin
                e = start_q.pop_front();
                chk("start_param", test_param_o, e);
            end
        end
        if (done_o) begin
            n_done++;
            if (done_q.size() == 0) chk("unexpected_done", 64'(n_done), 64'(0));
            else begin
                d = done_q.pop_front();
                chk("done_pass_cnt", 64'(pass_cnt_o), 64'(d.p));
                chk("done_fail_cnt", 64'(fail_cnt_o), 64'(d.f));
                chk("done_ff_valid", 64'(first_fail_valid_o), 64'(d.v));
                if (d.v) chk("done_ff_idx", 64'(first_fail_idx_o), 64'(d.i));
            end
        end
    end

    // Test-controller model: finishes each test 3 cycles after its start.
    initial begin
        int slot;
        test_finish_i = 1'b0;
        test_result_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (start_test_o && !hold) begin
                slot = int'(test_param_o[1][2:0]);
                repeat (3) @(posedge clk_i);
                #1;
                test_finish_i = 1'b1;
                test_result_i = (slot == fail_slot);
                @(posedge clk_i);
                #1;
                test_finish_i = 1'b0;
                test_result_i = 1'b0;
            end
        end
    end

    task automatic prog_write(input int slot, input bit word, input logic [31:0] data);
        @(posedge clk_i); #1;
        prog_we_i = 1'b1; prog_addr_i = 3'(slot); prog_word_i = word; prog_data_i = data;
        @(posedge clk_i); #1;
        prog_we_i = 1'b0;
    endtask

    task automatic do_run(input int len, input int loops, input bit soe);
        @(posedge clk_i); #1;
        prog_len_i = 4'(len); loops_i = 8'(loops); stop_on_err_i = soe; run_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        chk("done_seen", 64'(n_done), 64'(target));
    endtask

    task automatic wait_starts(input int target);
        int k = 0;
        while (n_starts < target && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        chk("start_seen", 64'(n_starts), 64'(target));
    endtask

    initial begin
        int base;
        rst_i = 1'b0; prog_we_i = 1'b0; prog_addr_i = '0; prog_word_i = 1'b0; prog_data_i = '0;
        prog_len_i = '0; loops_i = '0; stop_on_err_i = 1'b0; run_i = 1'b0; abort_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_start", 64'(start_test_o), 64'(0));
        chk("rst_counts", {pass_cnt_o, fail_cnt_o}, 64'(0));
        chk("rst_ff", {first_fail_valid_o, first_fail_idx_o}, 64'(0));
        chk("rst_param", test_param_o, 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        rst_i = 1'b1;
        for (int s = 0; s < 8; s++) begin
            prog_write(s, 1'b0, 32'h1000_0000 + s);
            prog_write(s, 1'b1, 32'h2000_0000 + s);
        end

        // Two passes of three slots; a write while busy must not disturb slot 0 on the reread.
        fail_slot = -1;
        base = n_starts;
        for (int p = 0; p < 2; p++) for (int s = 0; s < 3; s++) push_start(s);
        push_done(6, 0, 1'b0, 0);
        do_run(3, 2, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("busy_in_run", 64'(busy_o), 64'(1));
        prog_write(0, 1'b0, 32'hDEAD_BEEF);
        wait_done(1);
        chk("t1_starts", 64'(n_starts - base), 64'(6));
        repeat (5) @(negedge clk_i);
        chk("t1_hold_pass", 64'(pass_cnt_o), 64'(6));
        chk("t1_idle", 64'(busy_o), 64'(0));

        // Slot 2 fails, no stop-on-error.
        fail_slot = 2;
        base = n_starts;
        for (int s = 0; s < 4; s++) push_start(s);
        push_done(3, 1, 1'b1, 2);
        do_run(4, 1, 1'b0);
        wait_done(2);
        chk("t2_starts", 64'(n_starts - base), 64'(4));

        // Same with stop-on-error: run ends after slot 2.
        base = n_starts;
        for (int s = 0; s < 3; s++) push_start(s);
        push_done(2, 1, 1'b1, 2);
        do_run(4, 1, 1'b1);
        wait_done(3);
        chk("t3_starts", 64'(n_starts - base), 64'(3));

        // Endless loop over two slots, aborted during the 5th test.
        fail_slot = -1;
        base = n_starts;
        for (int k = 0; k < 5; k++) push_start(k % 2);
        push_done(5, 0, 1'b0, 0);
        do_run(2, 0, 1'b0);
        wait_starts(base + 5);
        @(posedge clk_i); #1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        wait_done(4);
        repeat (20) @(negedge clk_i);
        chk("t4_no_6th_start", 64'(n_starts - base), 64'(5));

        // Empty program: done two cycles after run, no starts.
        base = n_starts;
        push_done(0, 0, 1'b0, 0);
        do_run(0, 1, 1'b0);
        @(negedge clk_i);
        chk("len0_busy_c1", 64'(busy_o), 64'(1));
        chk("len0_done_c1", 64'(done_o), 64'(0));
        @(negedge clk_i);
        chk("len0_done_c2", 64'(done_o), 64'(1));
        // Oversized length is rejected the same way.
        push_done(0, 0, 1'b0, 0);
        do_run(9, 1, 1'b0);
        wait_done(6);
        chk("len_bad_starts", 64'(n_starts - base), 64'(0));

        // run and abort together: abort wins.
        @(posedge clk_i); #1;
        prog_len_i = 4'd2; run_i = 1'b1; abort_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0; abort_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("runabort_busy", 64'(busy_o), 64'(0));
        chk("runabort_done", 64'(n_done), 64'(6));

`ifdef MEM_SEQ_TIMEOUT_EN
        hold = 1'b1;
        push_start(0);
        push_done(0, 1, 1'b1, 0);
        do_run(1, 1, 1'b0);
        wait_done(7);
        chk("timeout_flag", 64'(timeout_o), 64'(1));
        hold = 1'b0;
`endif

        // Asynchronous reset while waiting on a test clears outputs immediately.
        base = n_starts;
        fail_slot = 1;
        push_start(0);
        do_run(2, 0, 1'b0);
        wait_starts(base + 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'(0));
        chk("arst_start_done", {start_test_o, done_o}, 64'(0));
        chk("arst_counts", {pass_cnt_o, fail_cnt_o}, 64'(0));
        chk("arst_param", test_param_o, 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("sb_starts_left", 64'(start_q.size()), 64'(0));
        chk("sb_dones_left", 64'(done_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
